// File: rtl/braille_chord_writer.sv
// braille_chord_writer: Perkins-style chord entry to ASCII.
// Data path: 2-FF synchronizers, shared debounce, chord accumulator FSM,
// Grade-1 decode, first-word-fall-through FIFO, valid/ready output.
// Optional feature macro: BRAILLE_NUMERIC_EN (numeric indicator 3456 + digits a-j).
module braille_chord_writer #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] dot_keys,
    input  logic       space_key,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       num_mode,
    output logic       overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EMIT
    } state_t;

    logic [6:0]       r_sync1;
    logic [6:0]       r_sync2;
    logic [6:0]       r_sampled;
    logic [6:0]       r_stableKeys;
    logic [CNT_W-1:0] r_debounceCnt;

    state_t           r_state;
    logic [6:0]       r_acc;

    logic [5:0]       w_dots;
    logic             w_space;
    logic [4:0]       w_letterIdx;
    logic             w_isLetter;
    logic             w_numMode;
    logic             w_decPush;
    logic [7:0]       w_decChar;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_pushReq;
    logic             w_pushOk;

    // Bring the seven raw key levels into the clock domain (space key is bit 6).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {space_key, dot_keys};
            r_sync2 <= r_sync1;
        end
    end

    // Adopt the synchronized vector only after it has held still long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sampled     <= '0;
            r_stableKeys  <= '0;
            r_debounceCnt <= '0;
        end else if (r_sync2 != r_sampled) begin
            r_sampled     <= r_sync2;
            r_debounceCnt <= '0;
        end else if (r_debounceCnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stableKeys  <= r_sampled;
        end else begin
            r_debounceCnt <= r_debounceCnt + CNT_W'(1);
        end
    end

    // Chord FSM: accumulate the union of keys until everything is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_stableKeys != 7'd0) begin
                        r_acc   <= r_stableKeys;
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    r_acc <= r_acc | r_stableKeys;
                    if (r_stableKeys == 7'd0) begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_dots  = r_acc[5:0];
    assign w_space = r_acc[6];

    // Map a dot pattern to its letter index a=0 .. z=25.
    always_comb begin
        w_isLetter  = 1'b1;
        w_letterIdx = 5'd0;
        case (w_dots)
            6'h01: w_letterIdx = 5'd0;
            6'h03: w_letterIdx = 5'd1;
            6'h09: w_letterIdx = 5'd2;
            6'h19: w_letterIdx = 5'd3;
            6'h11: w_letterIdx = 5'd4;
            6'h0B: w_letterIdx = 5'd5;
            6'h1B: w_letterIdx = 5'd6;
            6'h13: w_letterIdx = 5'd7;
            6'h0A: w_letterIdx = 5'd8;
            6'h1A: w_letterIdx = 5'd9;
            6'h05: w_letterIdx = 5'd10;
            6'h07: w_letterIdx = 5'd11;
            6'h0D: w_letterIdx = 5'd12;
            6'h1D: w_letterIdx = 5'd13;
            6'h15: w_letterIdx = 5'd14;
            6'h0F: w_letterIdx = 5'd15;
            6'h1F: w_letterIdx = 5'd16;
            6'h17: w_letterIdx = 5'd17;
            6'h0E: w_letterIdx = 5'd18;
            6'h1E: w_letterIdx = 5'd19;
            6'h25: w_letterIdx = 5'd20;
            6'h27: w_letterIdx = 5'd21;
            6'h3A: w_letterIdx = 5'd22;
            6'h2D: w_letterIdx = 5'd23;
            6'h3D: w_letterIdx = 5'd24;
            6'h35: w_letterIdx = 5'd25;
            default: w_isLetter = 1'b0;
        endcase
    end

`ifdef BRAILLE_NUMERIC_EN
    logic w_numSet;
    logic w_numClr;
    logic r_numMode;

    // Turn the accumulated chord into a character, with numeric-mode handling.
    always_comb begin
        w_decPush = 1'b0;
        w_decChar = 8'h00;
        w_numSet  = 1'b0;
        w_numClr  = 1'b0;
        if (w_space) begin
            if (w_dots == 6'd0) begin
                w_decPush = 1'b1;
                w_decChar = 8'h20;
                w_numClr  = 1'b1;
            end
        end else if (w_dots == 6'h3C) begin
            w_numSet = 1'b1;
        end else if (w_isLetter) begin
            w_decPush = 1'b1;
            if (w_numMode && (w_letterIdx < 5'd10)) begin
                w_decChar = (w_letterIdx == 5'd9) ? 8'h30 : (8'h31 + {3'b000, w_letterIdx});
            end else begin
                w_decChar = 8'h61 + {3'b000, w_letterIdx};
                w_numClr  = 1'b1;
            end
        end else begin
            w_decPush = 1'b1;
            w_decChar = 8'h3F;
            w_numClr  = 1'b1;
        end
    end

    // Numeric mode is set by the indicator chord and cleared by any non-digit emission.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_numMode <= 1'b0;
        end else if (r_state == ST_EMIT) begin
            if (w_numSet) begin
                r_numMode <= 1'b1;
            end else if (w_numClr) begin
                r_numMode <= 1'b0;
            end
        end
    end

    assign w_numMode = r_numMode;
`else
    // Turn the accumulated chord into a character; 3456 is a plain '#'.
    always_comb begin
        w_decPush = 1'b0;
        w_decChar = 8'h00;
        if (w_space) begin
            if (w_dots == 6'd0) begin
                w_decPush = 1'b1;
                w_decChar = 8'h20;
            end
        end else if (w_dots == 6'h3C) begin
            w_decPush = 1'b1;
            w_decChar = 8'h23;
        end else if (w_isLetter) begin
            w_decPush = 1'b1;
            w_decChar = (w_numMode && (w_letterIdx < 5'd10)) ? 8'h30 : (8'h61 + {3'b000, w_letterIdx});
        end else begin
            w_decPush = 1'b1;
            w_decChar = 8'h3F;
        end
    end

    assign w_numMode = 1'b0;
`endif

    assign num_mode = w_numMode;

    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && char_ready;
    assign w_pushReq = (r_state == ST_EMIT) && w_decPush;
    assign w_pushOk  = w_pushReq && (!w_full || w_pop);

    // FIFO storage; a full FIFO still accepts a write when the head leaves in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_pushOk) begin
            r_mem[r_wrPtr] <= w_decChar;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_pushOk && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_pushOk && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
            if (w_pushReq && !w_pushOk) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign char_valid = !w_empty;
    assign char_data  = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_braille_chord_writer.sv
// tb_braille_chord_writer: table-driven and randomized checks of braille_chord_writer
// against a dot-string reference model. Honors BRAILLE_NUMERIC_EN when defined.
module tb_braille_chord_writer;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] dotKeys;
    logic       spaceKey;
    logic [7:0] charData;
    logic       charValid;
    logic       charReady;
    logic       numMode;
    logic       overflow;

    int compareCount = 0;
    int failCount    = 0;

    logic [7:0] captured[$];
    logic [7:0] expectedQ[$];
    logic [5:0] letterMask[26];
    bit         modelNum;

    typedef struct {
        logic [6:0] keys;
        int         pushes;
        logic [7:0] ch;
    } vec_t;

    vec_t vecs[29];

    braille_chord_writer #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dot_keys(dotKeys),
        .space_key(spaceKey),
        .char_data(charData),
        .char_valid(charValid),
        .char_ready(charReady),
        .num_mode(numMode),
        .overflow(overflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Record every character the consumer accepts.
    always @(negedge clk) begin
        if (rst_n && charValid && charReady) begin
            captured.push_back(charData);
        end
    end

    function automatic string baseDots(input int i);
        case (i)
            0: return "1";
            1: return "12";
            2: return "14";
            3: return "145";
            4: return "15";
            5: return "124";
            6: return "1245";
            7: return "125";
            8: return "24";
            default: return "245";
        endcase
    endfunction

    function automatic logic [5:0] dotsToMask(input string s);
        logic [5:0] m;
        m = '0;
        for (int i = 0; i < s.len(); i++) begin
            m[s[i] - "1"] = 1'b1;
        end
        return m;
    endfunction

    task automatic buildLetters();
        for (int i = 0; i < 10; i++) begin
            letterMask[i]      = dotsToMask(baseDots(i));
            letterMask[10 + i] = letterMask[i] | dotsToMask("3");
        end
        letterMask[20] = letterMask[0] | dotsToMask("36");
        letterMask[21] = letterMask[1] | dotsToMask("36");
        letterMask[22] = dotsToMask("2456");
        letterMask[23] = letterMask[2] | dotsToMask("36");
        letterMask[24] = letterMask[3] | dotsToMask("36");
        letterMask[25] = letterMask[4] | dotsToMask("36");
    endtask

    // Reference model: what one released chord should produce.
    task automatic modelEmit(input logic [6:0] chord);
        logic [5:0] dots;
        int idx;
        dots = chord[5:0];
        idx  = -1;
        for (int i = 0; i < 26; i++) begin
            if (letterMask[i] == dots) idx = i;
        end
        if (chord[6]) begin
            if (dots == 6'd0) begin
                expectedQ.push_back(8'h20);
                modelNum = 1'b0;
            end
        end else if (dots == dotsToMask("3456")) begin
`ifdef BRAILLE_NUMERIC_EN
            modelNum = 1'b1;
`else
            expectedQ.push_back(8'h23);
`endif
        end else if (idx >= 0) begin
            if (modelNum && idx < 10) begin
                expectedQ.push_back((idx == 9) ? 8'h30 : 8'(8'h31 + idx));
            end else begin
                expectedQ.push_back(8'(8'h61 + idx));
                modelNum = 1'b0;
            end
        end else begin
            expectedQ.push_back(8'h3F);
            modelNum = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkCaptured(input string name);
        checkOutput({name, "_count"}, captured.size(), expectedQ.size());
        for (int i = 0; i < captured.size() && i < expectedQ.size(); i++) begin
            checkOutput($sformatf("%s_char%0d", name, i), captured[i], expectedQ[i]);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] keys, input int holdCycles);
        {spaceKey, dotKeys} = keys;
        waitCycles(holdCycles);
    endtask

    task automatic enterChord(input logic [6:0] keys);
        applyStimulus(keys, 12);
        applyStimulus(7'd0, 16);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        {spaceKey, dotKeys} = 7'd0;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(3);
    endtask

    initial begin
        logic [6:0] a;
        logic [6:0] b;
        logic [6:0] numChords[4];
        logic       numExpect[4];
        bit         found;
        buildLetters();

        rst_n = 1'b0;
        {spaceKey, dotKeys} = 7'd0;
        charReady = 1'b0;
        #23;
        checkOutput("resetCharData", charData, 8'h00);
        checkOutput("resetCharValid", charValid, 1'b0);
        checkOutput("resetNumMode", numMode, 1'b0);
        checkOutput("resetOverflow", overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        charReady = 1'b1;
        waitCycles(5);

        $display("[TB] reset in the middle of a chord");
        captured.delete();
        applyStimulus(7'h03, 14);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetValid", charValid, 1'b0);
        {spaceKey, dotKeys} = 7'd0;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(25);
        checkOutput("midResetNoChar", captured.size(), 0);

        $display("[TB] rolling chord b and its latency");
        captured.delete();
        applyStimulus(7'h01, 10);
        applyStimulus(7'h03, 10);
        applyStimulus(7'h02, 10);
        applyStimulus(7'h00, 0);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (dut.r_stableKeys == 7'd0) found = 1'b1;
            else waitCycles(1);
        end
        checkOutput("latencyStableSeen", found, 1'b1);
        waitCycles(1);
        checkOutput("latencyN1Valid", charValid, 1'b0);
        waitCycles(1);
        checkOutput("latencyN2Valid", charValid, 1'b1);
        checkOutput("latencyN2Data", charData, 8'h62);
        waitCycles(10);
        expectedQ = '{8'h62};
        checkCaptured("chordB");

        $display("[TB] debounce");
        captured.delete();
        for (int t = 0; t < 20; t++) begin
            applyStimulus((t % 2 == 0) ? 7'h01 : 7'h00, 2);
        end
        applyStimulus(7'h00, 20);
        checkOutput("bounceNoChar", captured.size(), 0);
        applyStimulus(7'h01, 20);
        applyStimulus(7'h00, 16);
        expectedQ = '{8'h61};
        checkCaptured("heldA");

        $display("[TB] decode sweep");
        for (int i = 0; i < 26; i++) begin
            vecs[i] = '{keys: {1'b0, letterMask[i]}, pushes: 1, ch: 8'(8'h61 + i)};
        end
        vecs[26] = '{keys: 7'h40, pushes: 1, ch: 8'h20};
        vecs[27] = '{keys: 7'h3F, pushes: 1, ch: 8'h3F};
        vecs[28] = '{keys: 7'h41, pushes: 0, ch: 8'h00};
        for (int i = 0; i < 29; i++) begin
            captured.delete();
            enterChord(vecs[i].keys);
            checkOutput($sformatf("decode%0d_count", i), captured.size(), vecs[i].pushes);
            if (vecs[i].pushes == 1 && captured.size() == 1) begin
                checkOutput($sformatf("decode%0d_char", i), captured[0], vecs[i].ch);
            end
        end

        $display("[TB] numeric indicator sequence");
        captured.delete();
        numChords = '{7'h3C, 7'h01, 7'h1A, 7'h05};
`ifdef BRAILLE_NUMERIC_EN
        numExpect = '{1'b1, 1'b1, 1'b1, 1'b0};
        expectedQ = '{8'h31, 8'h30, 8'h6B};
`else
        numExpect = '{1'b0, 1'b0, 1'b0, 1'b0};
        expectedQ = '{8'h23, 8'h61, 8'h6A, 8'h6B};
`endif
        for (int i = 0; i < 4; i++) begin
            enterChord(numChords[i]);
            checkOutput($sformatf("numMode%0d", i), numMode, numExpect[i]);
        end
        checkCaptured("numeric");
        applyStimulus(7'h40, 12);
        applyStimulus(7'h00, 16);

        $display("[TB] FIFO full and overflow");
        charReady = 1'b0;
        captured.delete();
        for (int i = 0; i < 5; i++) begin
            enterChord({1'b0, letterMask[i]});
        end
        checkOutput("fullOverflow", overflow, 1'b1);
        checkOutput("fullValid", charValid, 1'b1);
        for (int s = 0; s < 5; s++) begin
            checkOutput($sformatf("stallData%0d", s), charData, 8'h61);
            waitCycles(1);
        end
        charReady = 1'b1;
        waitCycles(10);
        expectedQ = '{8'h61, 8'h62, 8'h63, 8'h64};
        checkCaptured("drain");
        checkOutput("drainEmpty", charValid, 1'b0);
        checkOutput("overflowSticky", overflow, 1'b1);

        $display("[TB] randomized chords against the model");
        doReset();
        checkOutput("overflowClearedByReset", overflow, 1'b0);
        modelNum = 1'b0;
        expectedQ.delete();
        captured.delete();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: a = 7'($urandom_range(1, 127));
                1: a = {1'b0, letterMask[$urandom_range(0, 25)]};
                2: a = 7'h3C;
                default: a = 7'h40;
            endcase
            b = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
            applyStimulus(a, 10);
            applyStimulus(a | b, 10);
            applyStimulus(7'd0, 16);
            modelEmit(a | b);
            checkOutput($sformatf("randNumMode%0d", n), numMode, modelNum);
        end
        checkCaptured("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
